// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA stage: walks the KSA-permuted S memory, produces keystream bytes,
// XORs them with the encrypted ROM, and writes the plaintext to the decrypted RAM.
`timescale 1ns/1ps

module prga_decrypt_fsm #(
    parameter int MSG_LEN     = 32,
    parameter bit EARLY_ABORT = 1'b1,
    localparam int AW         = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [7:0]    s_address,
    output logic [7:0]    s_data,
    output logic          s_wren,
    input  logic [7:0]    s_q,
    output logic [AW-1:0] rom_address,
    input  logic [7:0]    rom_q,
    output logic [AW-1:0] ram_address,
    output logic [7:0]    ram_data,
    output logic          ram_wren,
    output logic          finish,
    output logic          msg_ok
);

    typedef enum logic [3:0] {
        IDLE, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, RD_F, LAT_F, WR_OUT, DONE
    } state_t;

    localparam logic [AW-1:0] LAST_K = AW'(MSG_LEN - 1);

    state_t        state;
    logic [7:0]    i;
    logic [7:0]    j;
    logic [7:0]    si;
    logic [7:0]    sj;
    logic [7:0]    f;
    logic [AW-1:0] k;

    // Plaintext is accepted only as lowercase letters or space.
    function automatic logic is_valid(input logic [7:0] b);
        return ((b >= 8'd97) && (b <= 8'd122)) || (b == 8'd32);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            si          <= '0;
            sj          <= '0;
            f           <= '0;
            s_address   <= '0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            rom_address <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            finish      <= 1'b0;
            msg_ok      <= 1'b0;
        end else begin
            // NOTE: write enables fall back low every cycle and are raised only on
            // entry to a write state; all state uses <= so each branch sees pre-edge values.
            s_wren   <= 1'b0;
            ram_wren <= 1'b0;

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        i         <= 8'd1;
                        j         <= 8'd0;
                        k         <= '0;
                        msg_ok    <= 1'b1;
                        finish    <= 1'b0;
                        s_address <= 8'd1;
                        state     <= RD_I;
                    end
                end
                RD_I: state <= LAT_I;
                LAT_I: begin
                    si        <= s_q;
                    j         <= j + s_q;
                    s_address <= j + s_q;
                    state     <= RD_J;
                end
                RD_J: state <= LAT_J;
                LAT_J: begin
                    sj        <= s_q;
                    s_address <= i;
                    s_data    <= s_q;
                    s_wren    <= 1'b1;
                    state     <= WR_I;
                end
                WR_I: begin
                    // When i == j this second write restores S[i] to si.
                    s_address <= j;
                    s_data    <= si;
                    s_wren    <= 1'b1;
                    state     <= WR_J;
                end
                WR_J: begin
                    s_address   <= si + sj;
                    rom_address <= k;
                    state       <= RD_F;
                end
                RD_F: state <= LAT_F;
                LAT_F: begin
                    f           <= s_q ^ rom_q;
                    ram_address <= k;
                    ram_data    <= s_q ^ rom_q;
                    ram_wren    <= 1'b1;
                    state       <= WR_OUT;
                end
                WR_OUT: begin
                    if (!is_valid(f)) begin
                        msg_ok <= 1'b0;
                    end
                    // The invalid byte has already been written before we abort.
                    if ((!is_valid(f) && EARLY_ABORT) || (k == LAST_K)) begin
                        finish <= 1'b1;
                        state  <= DONE;
                    end else begin
                        k         <= k + AW'(1);
                        i         <= i + 8'd1;
                        s_address <= i + 8'd1;
                        state     <= RD_I;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Self-checking bench for prga_decrypt_fsm: two instances (full-run and early-abort)
// with behavioural S/ROM/RAM models, compared against a plain RC4 reference model.
`timescale 1ns/1ps

module tb_prga_decrypt_fsm;

    localparam int LEN_A = 4;
    localparam int LEN_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst      [2];
    logic       start    [2];
    logic [7:0] s_addr   [2];
    logic [7:0] s_data   [2];
    logic       s_wren   [2];
    logic [7:0] s_q      [2];
    logic [7:0] rom_q    [2];
    logic [7:0] ram_data [2];
    logic       ram_wren [2];
    logic       fin      [2];
    logic       msg_ok   [2];
    logic [1:0] rom_addr_a, ram_addr_a;
    logic [2:0] rom_addr_b, ram_addr_b;
    logic [7:0] rom_addr [2];
    logic [7:0] ram_addr [2];

    always_comb begin
        rom_addr[0] = {6'd0, rom_addr_a};
        rom_addr[1] = {5'd0, rom_addr_b};
        ram_addr[0] = {6'd0, ram_addr_a};
        ram_addr[1] = {5'd0, ram_addr_b};
    end

    prga_decrypt_fsm #(.MSG_LEN(LEN_A), .EARLY_ABORT(1'b0)) dut_a (
        .clk(clk), .reset(rst[0]), .start(start[0]),
        .s_address(s_addr[0]), .s_data(s_data[0]), .s_wren(s_wren[0]), .s_q(s_q[0]),
        .rom_address(rom_addr_a), .rom_q(rom_q[0]),
        .ram_address(ram_addr_a), .ram_data(ram_data[0]), .ram_wren(ram_wren[0]),
        .finish(fin[0]), .msg_ok(msg_ok[0])
    );

    prga_decrypt_fsm #(.MSG_LEN(LEN_B), .EARLY_ABORT(1'b1)) dut_b (
        .clk(clk), .reset(rst[1]), .start(start[1]),
        .s_address(s_addr[1]), .s_data(s_data[1]), .s_wren(s_wren[1]), .s_q(s_q[1]),
        .rom_address(rom_addr_b), .rom_q(rom_q[1]),
        .ram_address(ram_addr_b), .ram_data(ram_data[1]), .ram_wren(ram_wren[1]),
        .finish(fin[1]), .msg_ok(msg_ok[1])
    );

    // Memory models: registered reads, S loadable from the bench, RAM writes logged.
    logic [7:0] s_mem   [2][256];
    logic [7:0] rom_mem [2][256];
    logic       ld_en   [2];
    logic [7:0] ld_addr, ld_data;
    int         wr_cnt  [2];
    int         log_addr[2][1024];
    int         log_data[2][1024];

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (ld_en[n] === 1'b1) s_mem[n][ld_addr] <= ld_data;
            else if (s_wren[n] === 1'b1) s_mem[n][s_addr[n]] <= s_data[n];
            s_q[n]   <= s_mem[n][s_addr[n]];
            rom_q[n] <= rom_mem[n][rom_addr[n]];
            if (ram_wren[n] === 1'b1) begin
                log_addr[n][wr_cnt[n] % 1024] <= int'(ram_addr[n]);
                log_data[n][wr_cnt[n] % 1024] <= int'(ram_data[n]);
                wr_cnt[n] <= wr_cnt[n] + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state and run observations.
    logic [7:0] s_img    [256];
    logic [7:0] m_s      [256];
    logic [7:0] exp_data [256];
    int         exp_n;
    logic       exp_ok;
    int         obs_cyc, obs_n;
    logic       obs_ok, obs_hold;
    int         obs_addr [256];
    int         obs_data [256];
    logic [7:0] obs_s    [256];

    byte unsigned t1_exp [4] = '{8'd2, 8'd5, 8'd7, 8'd13};
    byte unsigned t2_rom [4] = '{8'd99, 8'd103, 8'd100, 8'd105};
    byte unsigned t2_exp [4] = '{8'd97, 8'd98, 8'd99, 8'd100};

    // Textbook RC4 PRGA over a copy of s_img, XORed with this instance's ROM.
    task automatic model(input int n, input int len, input bit ea);
        int ii, jj;
        logic [7:0] t, fb;
        ii = 0;
        jj = 0;
        for (int a = 0; a < 256; a++) m_s[a] = s_img[a];
        exp_n  = 0;
        exp_ok = 1'b1;
        for (int kk = 0; kk < len; kk++) begin
            ii = (ii + 1) % 256;
            jj = (jj + int'(m_s[ii])) % 256;
            t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
            fb = m_s[(int'(m_s[ii]) + int'(m_s[jj])) % 256] ^ rom_mem[n][kk];
            exp_data[kk] = fb;
            exp_n = kk + 1;
            if (!(fb == 8'd32 || (fb >= 8'd97 && fb <= 8'd122))) begin
                exp_ok = 1'b0;
                if (ea) break;
            end
        end
    endtask

    task automatic set_identity();
        for (int a = 0; a < 256; a++) s_img[a] = 8'(a);
    endtask

    task automatic set_perm();
        logic [7:0] t;
        int b;
        set_identity();
        for (int a = 255; a > 0; a--) begin
            b = int'($urandom_range(0, a));
            t = s_img[a]; s_img[a] = s_img[b]; s_img[b] = t;
        end
    endtask

    task automatic load_s(input int n);
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            ld_en[n] = 1'b1;
            ld_addr  = 8'(a);
            ld_data  = s_img[a];
        end
        @(negedge clk);
        ld_en[n] = 1'b0;
    endtask

    // Pulse start, wait (bounded) for finish, and capture what the DUT produced.
    task automatic run_dut(input int n, input int len, input bit ea, input bit pulse);
        int base, cyc;
        model(n, len, ea);
        base = wr_cnt[n];
        @(negedge clk); start[n] = 1'b1;
        @(negedge clk); start[n] = 1'b0;
        cyc = 0;
        while (fin[n] !== 1'b1 && cyc < 9 * len + 20) begin
            start[n] = pulse && (cyc % 7 == 3);
            @(negedge clk);
            cyc++;
        end
        start[n] = 1'b0;
        obs_cyc = cyc;
        obs_ok  = msg_ok[n];
        obs_n   = wr_cnt[n] - base;
        repeat (3) @(negedge clk);
        obs_hold = (fin[n] === 1'b1) && (ram_wren[n] === 1'b0) && (wr_cnt[n] - base == obs_n);
        for (int kk = 0; kk < 256; kk++) begin
            obs_addr[kk] = (kk < obs_n) ? log_addr[n][(base + kk) % 1024] : -1;
            obs_data[kk] = (kk < obs_n) ? log_data[n][(base + kk) % 1024] : -1;
        end
        for (int a = 0; a < 256; a++) obs_s[a] = s_mem[n][a];
    endtask

    function automatic int data_errs();
        int e = 0;
        for (int kk = 0; kk < exp_n; kk++)
            if (obs_addr[kk] != kk || obs_data[kk] != int'(exp_data[kk])) e++;
        return e;
    endfunction

    function automatic int s_errs();
        int e = 0;
        for (int a = 0; a < 256; a++) if (obs_s[a] !== m_s[a]) e++;
        return e;
    endfunction

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            n_cmp++;
            if ({s_addr[n], s_data[n], s_wren[n], rom_addr[n], ram_addr[n], ram_data[n],
                 ram_wren[n], fin[n], msg_ok[n]} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: got s_addr=%h s_wren=%b ram_wren=%b finish=%b msg_ok=%b want all zero",
                         n, s_addr[n], s_wren[n], ram_wren[n], fin[n], msg_ok[n]);
            end
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        repeat (5) @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            n_cmp++;
            if (fin[n] !== 1'b0 || wr_cnt[n] != 0) begin
                n_bad++;
                $display("FAIL idle_quiet[%0d]: got finish=%b writes=%0d want 0 0", n, fin[n], wr_cnt[n]);
            end
        end
    endtask

    task automatic test_known_vectors();
        set_identity();
        for (int kk = 0; kk < 256; kk++) rom_mem[0][kk] = 8'd0;
        load_s(0);
        run_dut(0, LEN_A, 1'b0, 1'b0);
        n_cmp++;
        if (obs_cyc != 36) begin n_bad++; $display("FAIL t1_latency: got %0d want 36", obs_cyc); end
        n_cmp++;
        if (obs_n != 4) begin n_bad++; $display("FAIL t1_writes: got %0d want 4", obs_n); end
        for (int kk = 0; kk < 4; kk++) begin
            n_cmp++;
            if (obs_addr[kk] != kk || obs_data[kk] != int'(t1_exp[kk])) begin
                n_bad++;
                $display("FAIL t1_ram[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                         kk, obs_addr[kk], obs_data[kk], kk, t1_exp[kk]);
            end
        end
        n_cmp++;
        if (obs_ok !== 1'b0) begin n_bad++; $display("FAIL t1_msg_ok: got %b want 0", obs_ok); end
        n_cmp++;
        if ({obs_s[1], obs_s[2], obs_s[3], obs_s[4], obs_s[5], obs_s[9]} !==
            {8'd1, 8'd3, 8'd5, 8'd9, 8'd2, 8'd4}) begin
            n_bad++;
            $display("FAIL t1_s_final: got %0d %0d %0d %0d %0d %0d want 1 3 5 9 2 4",
                     obs_s[1], obs_s[2], obs_s[3], obs_s[4], obs_s[5], obs_s[9]);
        end
        n_cmp++;
        if (!obs_hold) begin n_bad++; $display("FAIL t1_done_hold: got 0 want 1"); end

        set_identity();
        for (int kk = 0; kk < 4; kk++) rom_mem[0][kk] = t2_rom[kk];
        load_s(0);
        run_dut(0, LEN_A, 1'b0, 1'b0);
        for (int kk = 0; kk < 4; kk++) begin
            n_cmp++;
            if (obs_data[kk] != int'(t2_exp[kk])) begin
                n_bad++;
                $display("FAIL t2_ram[%0d]: got %0d want %0d", kk, obs_data[kk], t2_exp[kk]);
            end
        end
        n_cmp++;
        if (obs_ok !== 1'b1 || obs_cyc != 36) begin
            n_bad++;
            $display("FAIL t2_ok_latency: got ok=%b cyc=%0d want ok=1 cyc=36", obs_ok, obs_cyc);
        end
    endtask

    task automatic test_back_to_back();
        set_identity();
        load_s(0);
        run_dut(0, LEN_A, 1'b0, 1'b1);
        n_cmp++;
        if (obs_n != 4 || obs_cyc != 36 || obs_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL t5_rerun: got writes=%0d cyc=%0d ok=%b want 4 36 1", obs_n, obs_cyc, obs_ok);
        end
        for (int kk = 0; kk < 4; kk++) begin
            n_cmp++;
            if (obs_addr[kk] != kk || obs_data[kk] != int'(t2_exp[kk])) begin
                n_bad++;
                $display("FAIL t5_ram[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                         kk, obs_addr[kk], obs_data[kk], kk, t2_exp[kk]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int base;
        set_identity();
        for (int kk = 0; kk < 256; kk++) rom_mem[0][kk] = 8'd0;
        load_s(0);
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        base = wr_cnt[0];
        repeat (22) @(negedge clk);
        // Byte k=2 is in WR_I here: S[3] <= S[5] = 5.
        n_cmp++;
        if (s_wren[0] !== 1'b1 || s_addr[0] !== 8'd3 || s_data[0] !== 8'd5) begin
            n_bad++;
            $display("FAIL t4_wr_i: got wren=%b addr=%0d data=%0d want 1 3 5", s_wren[0], s_addr[0], s_data[0]);
        end
        rst[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({s_addr[0], s_data[0], s_wren[0], rom_addr[0], ram_addr[0], ram_data[0],
             ram_wren[0], fin[0], msg_ok[0]} !== '0) begin
            n_bad++;
            $display("FAIL t4_reset_outputs: got s_addr=%h s_wren=%b ram_wren=%b finish=%b msg_ok=%b want all zero",
                     s_addr[0], s_wren[0], ram_wren[0], fin[0], msg_ok[0]);
        end
        rst[0] = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (wr_cnt[0] - base != 2 || fin[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL t4_aborted: got writes=%0d finish=%b want 2 0", wr_cnt[0] - base, fin[0]);
        end
        load_s(0);
        run_dut(0, LEN_A, 1'b0, 1'b0);
        for (int kk = 0; kk < 4; kk++) begin
            n_cmp++;
            if (obs_data[kk] != int'(t1_exp[kk])) begin
                n_bad++;
                $display("FAIL t4_ram[%0d]: got %0d want %0d", kk, obs_data[kk], t1_exp[kk]);
            end
        end
        n_cmp++;
        if (obs_cyc != 36 || obs_ok !== 1'b0) begin
            n_bad++;
            $display("FAIL t4_rerun: got cyc=%0d ok=%b want 36 0", obs_cyc, obs_ok);
        end
    endtask

    task automatic test_early_abort();
        set_identity();
        for (int kk = 0; kk < 256; kk++) rom_mem[1][kk] = 8'd0;
        load_s(1);
        run_dut(1, LEN_B, 1'b1, 1'b0);
        n_cmp++;
        if (obs_n != 1 || obs_addr[0] != 0 || obs_data[0] != 2) begin
            n_bad++;
            $display("FAIL t3_single_write: got n=%0d addr=%0d data=%0d want 1 0 2", obs_n, obs_addr[0], obs_data[0]);
        end
        n_cmp++;
        if (obs_cyc != 9 || obs_ok !== 1'b0 || !obs_hold) begin
            n_bad++;
            $display("FAIL t3_abort: got cyc=%0d ok=%b hold=%b want 9 0 1", obs_cyc, obs_ok, obs_hold);
        end
    endtask

    task automatic test_wrap();
        set_identity();
        s_img[1] = 8'd255; s_img[255] = 8'd1;
        s_img[2] = 8'd3;   s_img[3]   = 8'd2;
        for (int kk = 0; kk < 256; kk++) rom_mem[0][kk] = 8'($urandom_range(0, 255));
        load_s(0);
        run_dut(0, LEN_A, 1'b0, 1'b0);
        n_cmp++;
        if (obs_n != exp_n || data_errs() != 0) begin
            n_bad++;
            $display("FAIL t6_ram: got n=%0d bad=%0d want n=%0d bad=0", obs_n, data_errs(), exp_n);
        end
        n_cmp++;
        if (s_errs() != 0 || obs_ok !== exp_ok || obs_cyc != 9 * exp_n) begin
            n_bad++;
            $display("FAIL t6_state: got s_bad=%0d ok=%b cyc=%0d want 0 %b %0d",
                     s_errs(), obs_ok, obs_cyc, exp_ok, 9 * exp_n);
        end
    endtask

    task automatic test_random();
        int n, len, bad_pos;
        logic [7:0] p;
        for (int r = 0; r < 8; r++) begin
            n   = r % 2;
            len = (n == 1) ? LEN_B : LEN_A;
            set_perm();
            for (int kk = 0; kk < 256; kk++) rom_mem[n][kk] = 8'd0;
            if (n == 0 && r % 4 == 0) begin
                for (int kk = 0; kk < 256; kk++) rom_mem[n][kk] = 8'($urandom_range(0, 255));
            end else begin
                // Encrypt a chosen plaintext, optionally with one invalid byte.
                model(n, len, 1'b0);
                bad_pos = int'($urandom_range(0, len));
                for (int kk = 0; kk < len; kk++) begin
                    p = ($urandom_range(0, 26) == 26) ? 8'd32 : 8'(97 + $urandom_range(0, 25));
                    if (kk == bad_pos) p = 8'(33 + $urandom_range(0, 63));
                    rom_mem[n][kk] = exp_data[kk] ^ p;
                end
            end
            load_s(n);
            run_dut(n, len, (n == 1), (r % 3 == 0));
            n_cmp++;
            if (obs_n != exp_n || data_errs() != 0) begin
                n_bad++;
                $display("FAIL rand%0d_ram: got n=%0d bad=%0d want n=%0d bad=0", r, obs_n, data_errs(), exp_n);
            end
            n_cmp++;
            if (obs_ok !== exp_ok || obs_cyc != 9 * exp_n || s_errs() != 0 || !obs_hold) begin
                n_bad++;
                $display("FAIL rand%0d_state: got ok=%b cyc=%0d s_bad=%0d hold=%b want %b %0d 0 1",
                         r, obs_ok, obs_cyc, s_errs(), obs_hold, exp_ok, 9 * exp_n);
            end
        end
    endtask

    initial begin
        rst[0] = 1'b1; rst[1] = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        ld_en[0] = 1'b0; ld_en[1] = 1'b0;
        ld_addr = 8'd0; ld_data = 8'd0;
        for (int kk = 0; kk < 256; kk++) begin
            rom_mem[0][kk] = 8'd0;
            rom_mem[1][kk] = 8'd0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_reset_mid_run();
        test_early_abort();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
